// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One bit per clock; four BCD digits latched on completion.
module bin2bcd_seq #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd0,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a request that is accepted only on an edge where
    // busy is low; it is not queued otherwise. Every accepted request yields
    // exactly one done pulse, in the cycle the new digits first appear.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0]    sreg;
    logic [15:0]         scratch;
    logic [3:0]          cnt;
    logic [15:0]         adj;
    logic [16+WIDTH-1:0] shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (cnt == 4'd1) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Correct every digit that would overflow past 9 when doubled.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {adj, sreg} << 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            bcd3    <= '0;
            bcd2    <= '0;
            bcd1    <= '0;
            bcd0    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= bin;
                        scratch <= '0;
                        cnt     <= 4'(WIDTH);
                    end
                end
                SHIFT: begin
                    scratch <= shifted[16+WIDTH-1:WIDTH];
                    sreg    <= shifted[WIDTH-1:0];
                    cnt     <= cnt - 4'd1;
                end
                DONE: begin
                    bcd3 <= scratch[15:12];
                    bcd2 <= scratch[11:8];
                    bcd1 <= scratch[7:4];
                    bcd0 <= scratch[3:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, arithmetic reference
// model with random values, and hand-written multi-cycle corner sequences.
module tb_bin2bcd_seq;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic         busy, done;
    logic [3:0]   bcd3, bcd2, bcd1, bcd0;
    logic [1:0]   state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    bin2bcd_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy), .done(done),
        .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] value;
        logic [15:0]  expect_bcd;
    } vec_t;

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Drive one request from an idle DUT and check latency, busy span, result.
    task automatic run_conv(input logic [W-1:0] v, input logic [15:0] want, input string name);
        int lat;
        int busy_n;
        logic seen;
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        bin = v;
        exp_q.push_back(want);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, seen ? lat : 0, W + 2);
        check({name, "_busy_cycles"}, busy_n, W + 1);
        if (exp_q.size() > 0) check({name, "_digits"}, digits(), exp_q.pop_front());
        @(negedge clk);
        check({name, "_done_single"}, done, 1'b0);
    endtask

    vec_t vecs[11];

    initial begin
        int ndone;
        int last;
        logic [15:0] cap;
        logic [W-1:0] rv;

        vecs[0]  = '{10'd0,    16'h0000};
        vecs[1]  = '{10'd1023, 16'h1023};
        vecs[2]  = '{10'd999,  16'h0999};
        vecs[3]  = '{10'd510,  16'h0510};
        vecs[4]  = '{10'd5,    16'h0005};
        vecs[5]  = '{10'd9,    16'h0009};
        vecs[6]  = '{10'd10,   16'h0010};
        vecs[7]  = '{10'd99,   16'h0099};
        vecs[8]  = '{10'd100,  16'h0100};
        vecs[9]  = '{10'd555,  16'h0555};
        vecs[10] = '{10'd1000, 16'h1000};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_digits", digits(), 16'h0000);
        check("rst_state", state_dbg, 2'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].value, vecs[i].expect_bcd, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            rv = W'($urandom_range(0, (1 << W) - 1));
            run_conv(rv, ref_bcd(int'(rv)), $sformatf("rand%0d", i));
        end

        // second request during conversion is dropped
        @(negedge clk);
        start = 1'b1;
        bin = 10'd42;
        exp_q.push_back(ref_bcd(42));
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin = 10'd7;
        @(negedge clk);
        start = 1'b0;
        bin = '0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap = digits();
            end
        end
        check("drop_done_count", ndone, 1);
        check("drop_digits", cap, exp_q.pop_front());
        check("drop_idle_after", busy, 1'b0);

        // input changes after acceptance do not matter
        @(negedge clk);
        start = 1'b1;
        bin = 10'd123;
        @(negedge clk);
        start = 1'b0;
        bin = '0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap = digits();
            end
        end
        check("hold_done_count", ndone, 1);
        check("hold_digits", cap, 16'h0123);

        // reset mid-conversion; rebuild prior result 0042 first
        run_conv(10'd42, 16'h0042, "prior");
        check("prior_held", digits(), 16'h0042);
        @(negedge clk);
        start = 1'b1;
        bin = 10'd777;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        #1 reset_n = 1'b0;
        #1;
        check("abort_busy_async", busy, 1'b0);
        check("abort_digits_async", digits(), 16'h0000);
        check("abort_state_async", state_dbg, 2'd0);
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_digits", digits(), 16'h0000);
        check("abort_busy", busy, 1'b0);
        reset_n = 1'b1;
        run_conv(10'd5, 16'h0005, "after_rst");

        // start held high: back-to-back conversions
        @(negedge clk);
        start = 1'b1;
        bin = 10'd314;
        ndone = 0;
        last = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("b2b_digits", digits(), 16'h0314);
                if (last >= 0) check("b2b_period", i - last, W + 2);
                last = i;
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 5);
        repeat (3) @(negedge clk);
        check("b2b_idle", busy, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10; binary input width, legal range 1..13, so that 4 BCD digits always suffice.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port bin  input  WIDTH  unsigned binary value, captured when start is accepted.
REQ-006 The block SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 The block SHALL have port done  output  1  single-cycle pulse marking a result update.
REQ-008 The block SHALL have ports bcd3, bcd2, bcd1, bcd0  output  4 each  thousands, hundreds, tens and ones digit; each feeds one 7-segment decoder.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-010 In IDLE with start=1 at an edge, the block SHALL capture bin into a shift register, clear the 16-bit digit scratch register, load the shift counter with WIDTH and enter SHIFT.
REQ-011 In IDLE with start=0, the block SHALL hold all state.
REQ-012 In each SHIFT cycle, the block SHALL first add 3 to every scratch digit whose value is >= 5, then shift the combined {scratch, binary} register left by 1, and decrement the counter.
REQ-013 When the counter reaches 0 after the WIDTH-th shift, the block SHALL enter DONE.
REQ-014 In DONE, the block SHALL copy the scratch digits to bcd3..bcd0, assert done for exactly that one cycle, and return to IDLE.
REQ-015 Latency: if start is accepted at edge k, the outputs SHALL update and done SHALL go high after edge k+WIDTH+1 (11 cycles for WIDTH=10).
REQ-016 busy SHALL equal (state != IDLE); it is low in the cycle in which start is sampled and high from edge k+1 through the DONE cycle.
REQ-017 start SHALL be ignored while in SHIFT or DONE; an ignored request is not queued.
REQ-018 Changes to bin after acceptance SHALL NOT affect the result in progress.
REQ-019 bcd3..bcd0 SHALL hold the last completed result until the next DONE cycle; they never show partial scratch values.
REQ-020 Every digit output SHALL be in the range 0..9; the values 10..15 SHALL never appear.
REQ-021 For an input of all ones (1023 for WIDTH=10), the result SHALL be 1,0,2,3 with no overflow; no overflow flag exists.
REQ-022 Back-to-back operation: start sampled in the IDLE cycle immediately after DONE SHALL be accepted, giving a minimum period of WIDTH+2 cycles per conversion.

Reset
REQ-023 While reset_n=0, the block SHALL be in state IDLE with busy=0, done=0, bcd3..bcd0=0 and counter, scratch and shift registers at 0, independent of clk.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion immediately and SHALL NOT produce a done pulse; outputs SHALL read 0.
REQ-025 After reset_n rises, the first start at a clock edge SHALL be accepted normally.

Verification
REQ-026 Check: reset, then start with bin=0 -> after 11 cycles done=1 for one cycle and digits 0,0,0,0; busy high for exactly 11 cycles.
REQ-027 Check: bin=1023 -> digits 1,0,2,3; bin=999 -> 0,9,9,9; bin=510 -> 0,5,1,0 (exercises the add-3 at exactly 5).
REQ-028 Check: start with bin=42, then pulse start with bin=7 at cycle 4 -> single done, digits 0,0,4,2; second request dropped.
REQ-029 Check: start with bin=123, change bin to 0 on the next cycle -> result 0,1,2,3.
REQ-030 Check: prior result 0,0,4,2, then start bin=777 and drop reset_n at cycle 5 -> no done pulse, outputs 0, busy=0 during reset; after release, start bin=5 -> 0,0,0,5.
REQ-031 Check: hold start=1 continuously with bin=314 -> done every 12 cycles, digits 0,3,1,4 each time.
